data_mem_ctrl: RTL and testbench

//   Parametrised data memory for the core's load/store unit, successor to the fixed-size data RAM.

---
 rtl/data_mem_ctrl_if.sv | 30 +++
 rtl/data_mem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the MEM stage and data_mem_ctrl.
// The master issues valid/ready requests; the slave returns a one-cycle response pulse.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [3:0]        req_type;
  logic              req_sign;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              o_memory_address_misaligned;
  logic              o_memory_address_out_of_range;

  modport master (
    output req_valid, req_we, req_type, req_sign, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           o_memory_address_misaligned, o_memory_address_out_of_range
  );

  modport slave (
    input  req_valid, req_we, req_type, req_sign, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           o_memory_address_misaligned, o_memory_address_out_of_range
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Load/store data memory: byte/half/word accesses with extension, fault detection,
// single-cycle registered response and an optional zeroing sweep after reset.
module data_mem_ctrl #(
  parameter int                 ADDR_W         = 32,
  parameter int                 DEPTH_WORDS    = 2048,
  parameter logic [ADDR_W-1:0]  BASE_ADDR      = {ADDR_W{1'b0}},
  parameter int                 CLEAR_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  data_mem_ctrl_if.slave  bus
);

  localparam int              IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [0:0]      ST_INIT = 1'b0;
  localparam logic [0:0]      ST_RUN  = 1'b1;
  localparam logic [0:0]      ST_RST  = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADDR_W:0] SPAN    = (ADDR_W+1)'(DEPTH_WORDS * 4);
  localparam logic [3:0]      T_BYTE  = 4'b0001;
  localparam logic [3:0]      T_HALF  = 4'b0011;
  localparam logic [3:0]      T_WORD  = 4'b1111;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mis_q, mis_d;
  logic              oor_q, oor_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [ADDR_W-1:0] off_s;
  logic [IDX_W-1:0]  idx_s;
  logic [1:0]        lane_s;
  logic [4:0]        shamt_s;
  logic              legal_s, mis_s, oor_s, fault_s, accept_s;
  logic [31:0]       word_s, shifted_s, load_s, wshift_s, wmerge_s;
  logic [3:0]        be_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_idx_s;
  logic [31:0]       mem_wdata_s;

  // Address decode and fault classification of the presented request
  always_comb begin
    off_s   = bus.req_addr - BASE_ADDR;
    idx_s   = off_s[IDX_W+1:2];
    lane_s  = off_s[1:0];
    shamt_s = {lane_s, 3'b000};
    case (bus.req_type)
      T_BYTE: begin legal_s = 1'b1; mis_s = 1'b0;      end
      T_HALF: begin legal_s = 1'b1; mis_s = lane_s[0]; end
      T_WORD: begin legal_s = 1'b1; mis_s = |lane_s;   end
      default: begin legal_s = 1'b0; mis_s = 1'b0;     end
    endcase
    // Address flags describe legal-type requests only; an illegal type reports neither.
    oor_s    = legal_s & ((bus.req_addr < BASE_ADDR) | ({1'b0, off_s} >= SPAN));
    fault_s  = ~legal_s | mis_s | oor_s;
    accept_s = bus.req_valid & ready_q;
  end

  // Load extraction and store byte-lane merge against the addressed word
  always_comb begin
    word_s    = mem_q[idx_s];
    shifted_s = word_s >> shamt_s;
    case (bus.req_type)
      T_BYTE:  load_s = bus.req_sign ? {{24{shifted_s[7]}}, shifted_s[7:0]}
                                     : {24'h000000, shifted_s[7:0]};
      T_HALF:  load_s = bus.req_sign ? {{16{shifted_s[15]}}, shifted_s[15:0]}
                                     : {16'h0000, shifted_s[15:0]};
      default: load_s = shifted_s;
    endcase
    be_s     = bus.req_type << lane_s;
    wshift_s = bus.req_wdata << shamt_s;
    for (int i = 0; i < 4; i++) begin
      wmerge_s[8*i +: 8] = be_s[i] ? wshift_s[8*i +: 8] : word_s[8*i +: 8];
    end
  end

  // Single write port shared by the clear sweep and accepted stores
  always_comb begin
    if (state_q == ST_INIT) begin
      mem_we_s    = 1'b1;
      mem_idx_s   = cnt_q;
      mem_wdata_s = 32'h0000_0000;
    end else begin
      mem_we_s    = accept_s & bus.req_we & ~fault_s;
      mem_idx_s   = idx_s;
      mem_wdata_s = wmerge_s;
    end
  end

  // Sweep/run sequencing and the next response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: begin
        state_d = ST_INIT;
        cnt_d   = {IDX_W{1'b0}};
      end
    endcase
    ready_d     = (state_d == ST_RUN);
    rsp_valid_d = accept_s;
    rsp_err_d   = accept_s & fault_s;
    mis_d       = accept_s & mis_s;
    oor_d       = accept_s & oor_s;
    if (accept_s & ~bus.req_we & ~fault_s) begin
      rdata_d = load_s;
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // Array storage, no reset on the RAM itself
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_idx_s] <= mem_wdata_s;
    end
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      cnt_q       <= {IDX_W{1'b0}};
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      mis_q       <= 1'b0;
      oor_q       <= 1'b0;
      rdata_q     <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      mis_q       <= mis_d;
      oor_q       <= oor_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.req_ready                     = ready_q;
  assign bus.rsp_valid                     = rsp_valid_q;
  assign bus.rsp_rdata                     = rdata_q;
  assign bus.rsp_err                       = rsp_err_q;
  assign bus.o_memory_address_misaligned   = mis_q;
  assign bus.o_memory_address_out_of_range = oor_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (2048 words, base 0, clear-on-reset).
// Response vector layout: {valid, err, misaligned, out_of_range, rdata[31:0]}.
module tb_data_mem_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  typedef struct packed {
    logic        we;
    logic [3:0]  typ;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [35:0] exp;
  } vec_t;

  data_mem_ctrl_if #(.ADDR_W(32)) bus ();

  data_mem_ctrl #(
    .ADDR_W(32), .DEPTH_WORDS(2048), .BASE_ADDR(32'h0000_0000), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [35:0] rsp_vec;
  assign rsp_vec = {bus.rsp_valid, bus.rsp_err, bus.o_memory_address_misaligned,
                    bus.o_memory_address_out_of_range, bus.rsp_rdata};

  // One request for one cycle; returns the response seen on the following negedge.
  task automatic xact(input logic we, input logic [3:0] typ, input logic sign,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [35:0] obs);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_type  = typ;
    bus.req_sign  = sign;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    obs = rsp_vec;
  endtask

  // Called at the negedge where rst_n rises; counts cycles until req_ready.
  task automatic wait_init(output int n);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [35:0] obs;
    int n;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.req_ready, rsp_vec} !== 37'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", {bus.req_ready, rsp_vec}, 37'h0);
    end
    rst_n = 1'b1;
    wait_init(n);
    checks++;
    if (n !== 2048) begin
      failures++;
      $display("FAIL init_cycles got=%0d exp=%0d", n, 2048);
    end
    xact(1'b0, 4'b1111, 1'b0, 32'h40, 32'h0, obs);
    checks++;
    if (obs !== 36'h8_0000_0000) begin
      failures++;
      $display("FAIL load_after_clear got=%h exp=%h", obs, 36'h8_0000_0000);
    end
  endtask

  task automatic test_store_load();
    vec_t tbl[10];
    logic [35:0] obs;
    tbl[0] = '{1'b1, 4'b1111, 1'b0, 32'h40, 32'hDEADBEEF, 36'h8_0000_0000};
    tbl[1] = '{1'b0, 4'b0001, 1'b1, 32'h42, 32'h0,        36'h8_FFFF_FFAD};
    tbl[2] = '{1'b0, 4'b0001, 1'b0, 32'h42, 32'h0,        36'h8_0000_00AD};
    tbl[3] = '{1'b0, 4'b0011, 1'b1, 32'h40, 32'h0,        36'h8_FFFF_BEEF};
    tbl[4] = '{1'b0, 4'b0011, 1'b0, 32'h42, 32'h0,        36'h8_0000_DEAD};
    tbl[5] = '{1'b0, 4'b0011, 1'b1, 32'h42, 32'h0,        36'h8_FFFF_DEAD};
    tbl[6] = '{1'b0, 4'b1111, 1'b1, 32'h40, 32'h0,        36'h8_DEAD_BEEF};
    tbl[7] = '{1'b0, 4'b0001, 1'b0, 32'h43, 32'h0,        36'h8_0000_00DE};
    tbl[8] = '{1'b1, 4'b0011, 1'b0, 32'h46, 32'hAAAA5678, 36'h8_0000_0000};
    tbl[9] = '{1'b0, 4'b1111, 1'b0, 32'h44, 32'h0,        36'h8_5678_0000};
    for (int i = 0; i < 10; i++) begin
      xact(tbl[i].we, tbl[i].typ, tbl[i].sign, tbl[i].addr, tbl[i].wdata, obs);
      checks++;
      if (obs !== tbl[i].exp) begin
        failures++;
        $display("FAIL store_load[%0d] got=%h exp=%h", i, obs, tbl[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_type  = 4'b0001;
    bus.req_sign  = 1'b0;
    bus.req_addr  = 32'h41;
    bus.req_wdata = 32'h0000_00FF;
    @(posedge clk);
    #1;
    bus.req_we    = 1'b0;
    bus.req_type  = 4'b1111;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'h0;
    @(negedge clk);
    checks++;
    if (rsp_vec !== 36'h8_0000_0000) begin
      failures++;
      $display("FAIL b2b_store_rsp got=%h exp=%h", rsp_vec, 36'h8_0000_0000);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_vec !== 36'h8_DEAD_FFEF) begin
      failures++;
      $display("FAIL b2b_raw_load got=%h exp=%h", rsp_vec, 36'h8_DEAD_FFEF);
    end
    @(negedge clk);
    checks++;
    if (rsp_vec !== 36'h0) begin
      failures++;
      $display("FAIL b2b_pulse_end got=%h exp=%h", rsp_vec, 36'h0);
    end
  endtask

  task automatic test_faults();
    vec_t tbl[12];
    logic [35:0] obs;
    tbl[0]  = '{1'b1, 4'b1111, 1'b0, 32'h44,       32'h11223344, 36'h8_0000_0000};
    tbl[1]  = '{1'b0, 4'b1111, 1'b0, 32'h42,       32'h0,        36'hE_0000_0000};
    tbl[2]  = '{1'b1, 4'b0011, 1'b0, 32'h45,       32'h1234,     36'hE_0000_0000};
    tbl[3]  = '{1'b0, 4'b1111, 1'b0, 32'h44,       32'h0,        36'h8_1122_3344};
    tbl[4]  = '{1'b0, 4'b1111, 1'b0, 32'h2000,     32'h0,        36'hD_0000_0000};
    tbl[5]  = '{1'b1, 4'b1111, 1'b0, 32'h2002,     32'h55555555, 36'hF_0000_0000};
    tbl[6]  = '{1'b0, 4'b0001, 1'b0, 32'h1FFF,     32'h0,        36'h8_0000_0000};
    tbl[7]  = '{1'b0, 4'b0111, 1'b0, 32'h40,       32'h0,        36'hC_0000_0000};
    tbl[8]  = '{1'b1, 4'b0000, 1'b0, 32'h44,       32'hFFFFFFFF, 36'hC_0000_0000};
    tbl[9]  = '{1'b0, 4'b1111, 1'b0, 32'h44,       32'h0,        36'h8_1122_3344};
    tbl[10] = '{1'b0, 4'b0011, 1'b1, 32'h1FFE,     32'h0,        36'h8_0000_0000};
    tbl[11] = '{1'b0, 4'b1111, 1'b0, 32'hFFFFFFFC, 32'h0,        36'hD_0000_0000};
    for (int i = 0; i < 12; i++) begin
      xact(tbl[i].we, tbl[i].typ, tbl[i].sign, tbl[i].addr, tbl[i].wdata, obs);
      checks++;
      if (obs !== tbl[i].exp) begin
        failures++;
        $display("FAIL faults[%0d] got=%h exp=%h", i, obs, tbl[i].exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] obs;
    int n;
    // Reset with a load response on the bus
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_type  = 4'b1111;
    bus.req_sign  = 1'b0;
    bus.req_addr  = 32'h40;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    checks++;
    if (rsp_vec !== 36'h8_DEAD_FFEF) begin
      failures++;
      $display("FAIL pending_rsp got=%h exp=%h", rsp_vec, 36'h8_DEAD_FFEF);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, rsp_vec} !== 37'h0) begin
      failures++;
      $display("FAIL rst_drops_rsp got=%h exp=%h", {bus.req_ready, rsp_vec}, 37'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Interrupt the sweep at cycle 100
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, rsp_vec} !== 37'h0) begin
      failures++;
      $display("FAIL rst_mid_init got=%h exp=%h", {bus.req_ready, rsp_vec}, 37'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n);
    checks++;
    if (n !== 2048) begin
      failures++;
      $display("FAIL init_rerun_cycles got=%0d exp=%0d", n, 2048);
    end
    xact(1'b0, 4'b1111, 1'b0, 32'h40, 32'h0, obs);
    checks++;
    if (obs !== 36'h8_0000_0000) begin
      failures++;
      $display("FAIL cleared_after_rerun got=%h exp=%h", obs, 36'h8_0000_0000);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_type  = 4'b0000;
    bus.req_sign  = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    test_reset();
    test_store_load();
    test_back_to_back();
    test_faults();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
